// File: rtl/memory_access_unit.sv
// M-stage memory access unit: issues one aligned load/store per instruction,
// stalls the E/M register until the access completes and extends load data.
module memory_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ResultSrcM_i,
  input  logic [2:0]  MemWriteM_i,
  input  logic [2:0]  LoadTypeM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] ReadDataM_o,
  output logic        StallM_o,
  output logic        MisalignM_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  lane_q;
  logic [2:0]  ld_type_q;
  logic        load_q;

  logic        is_store, is_load, access, misaligned, aligned_access;
  logic [31:0] wdata_d, rdata_d, lane_word;
  logic [3:0]  wstrb_d;

  // A valid store code wins over a load select on the same instruction.
  assign is_store       = (MemWriteM_i == 3'b001) || (MemWriteM_i == 3'b010) ||
                          (MemWriteM_i == 3'b011);
  assign is_load        = !is_store && (ResultSrcM_i == 2'b01);
  assign access         = is_store || is_load;
  assign aligned_access = access && !misaligned;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    wstrb_d    = 4'b0000;
    wdata_d    = 32'h0;
    if (is_store) begin
      case (MemWriteM_i)
        3'b001: begin
          wstrb_d = 4'b0001 << ALUResultM_i[1:0];
          wdata_d = {4{WriteDataM_i[7:0]}};
        end
        3'b010: begin
          misaligned = ALUResultM_i[0];
          wstrb_d    = 4'b0011 << ALUResultM_i[1:0];
          wdata_d    = {2{WriteDataM_i[15:0]}};
        end
        default: begin
          misaligned = (ALUResultM_i[1:0] != 2'b00);
          wstrb_d    = 4'b1111;
          wdata_d    = WriteDataM_i;
        end
      endcase
    end else if (is_load) begin
      case (LoadTypeM_i[1:0])
        2'b01:   misaligned = ALUResultM_i[0];
        2'b10:   misaligned = (ALUResultM_i[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign lane_word = mem_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    case (ld_type_q)
      3'b000:  rdata_d = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  rdata_d = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  rdata_d = {24'h0, lane_word[7:0]};
      3'b101:  rdata_d = {16'h0, lane_word[15:0]};
      default: rdata_d = mem_rdata_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'b0000;
      lane_q    <= 2'b00;
      ld_type_q <= 3'b000;
      load_q    <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (aligned_access) begin
          state_q   <= BUSY;
          we_q      <= is_store;
          addr_q    <= {ALUResultM_i[31:2], 2'b00};
          wdata_q   <= wdata_d;
          wstrb_q   <= wstrb_d;
          lane_q    <= ALUResultM_i[1:0];
          ld_type_q <= LoadTypeM_i;
          load_q    <= is_load;
        end
        BUSY: if (mem_ready_i) begin
          state_q <= DONE;
          if (load_q) rdata_q <= rdata_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus fields are captured on entry to BUSY, so they cannot move during the request.
  assign mem_req_o   = (state_q == BUSY);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign ReadDataM_o = rdata_q;
  assign StallM_o    = aligned_access && (state_q != DONE);
  assign MisalignM_o = access && misaligned && (state_q == IDLE);

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit; expected load results go through a
// scoreboard queue and are popped when the access reaches DONE.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ResultSrcM_i;
  logic [2:0]  MemWriteM_i, LoadTypeM_i;
  logic [31:0] ALUResultM_i, WriteDataM_i, mem_rdata_i;
  logic        mem_ready_i;
  logic        mem_req_o, mem_we_o, StallM_o, MisalignM_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ReadDataM_o;
  logic [3:0]  mem_wstrb_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  memory_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ResultSrcM_i(ResultSrcM_i), .MemWriteM_i(MemWriteM_i), .LoadTypeM_i(LoadTypeM_i),
    .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .ReadDataM_o(ReadDataM_o),
    .StallM_o(StallM_o), .MisalignM_o(MisalignM_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ResultSrcM_i = 2'b00;
    MemWriteM_i  = 3'b000;
    LoadTypeM_i  = 3'b000;
    ALUResultM_i = 32'h0;
    WriteDataM_i = 32'h0;
  endtask

  // One aligned access: st==0 means a load of type ld. mem_ready_i rises after wait_cyc BUSY cycles.
  task automatic access(input string tag, input logic [2:0] st, input logic [2:0] ld,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int wait_cyc,
                        input logic [31:0] exp_rd, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input logic exp_we);
    int stall_cnt = 0;
    @(posedge clk); #1;
    ResultSrcM_i = (st == 3'b000) ? 2'b01 : 2'b00;
    MemWriteM_i  = st;
    LoadTypeM_i  = ld;
    ALUResultM_i = addr;
    WriteDataM_i = wdata;
    mem_ready_i  = 1'b0;
    mem_rdata_i  = 32'h0;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    check({tag, "/req_idle"}, mem_req_o, 32'd0);
    check({tag, "/misalign"}, MisalignM_o, 32'd0);
    if (StallM_o) stall_cnt++;
    for (int i = 0; i <= wait_cyc; i++) begin
      @(posedge clk); #1;
      if (i == wait_cyc) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = rdata;
      end
      @(negedge clk);
      check({tag, "/req_busy"}, mem_req_o, 32'd1);
      check({tag, "/addr"}, mem_addr_o, exp_addr);
      check({tag, "/we"}, mem_we_o, exp_we);
      check({tag, "/wstrb"}, mem_wstrb_o, exp_wstrb);
      if (exp_we) check({tag, "/wdata"}, mem_wdata_o, exp_wdata);
      if (StallM_o) stall_cnt++;
    end
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hA5A5_A5A5;
    @(negedge clk);
    check({tag, "/req_done"}, mem_req_o, 32'd0);
    if (StallM_o) stall_cnt++;
    check({tag, "/stall_cycles"}, stall_cnt, wait_cyc + 2);
    check({tag, "/rdata"}, ReadDataM_o, exp_q.pop_front());
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({tag, "/req_after"}, mem_req_o, 32'd0);
    check({tag, "/stall_after"}, StallM_o, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    idle_inputs();
    #1;
    check("reset/req", mem_req_o, 32'd0);
    check("reset/rdata", ReadDataM_o, 32'h0);
    check("reset/stall", StallM_o, 32'd0);
    #11 rst_n = 1'b1;

    access("lw_100", 3'b000, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
           32'hDEAD_BEEF, 32'h100, 32'h0, 4'b0000, 1'b0);
    access("lb_103", 3'b000, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
           32'hFFFF_FF80, 32'h100, 32'h0, 4'b0000, 1'b0);
    access("lbu_103", 3'b000, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0,
           32'h0000_0080, 32'h100, 32'h0, 4'b0000, 1'b0);
    access("lh_102", 3'b000, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 2,
           32'hFFFF_8001, 32'h100, 32'h0, 4'b0000, 1'b0);
    access("lhu_100", 3'b000, 3'b101, 32'h100, 32'h0, 32'h8001_F00D, 0,
           32'h0000_F00D, 32'h100, 32'h0, 4'b0000, 1'b0);
    access("sh_202", 3'b010, 3'b000, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 1,
           32'h0000_F00D, 32'h200, 32'hABCD_ABCD, 4'b1100, 1'b1);
    access("sw_300", 3'b011, 3'b000, 32'h300, 32'hCAFE_F00D, 32'h5555_5555, 5,
           32'h0000_F00D, 32'h300, 32'hCAFE_F00D, 4'b1111, 1'b1);
    access("sb_301", 3'b001, 3'b000, 32'h301, 32'h0000_00A7, 32'h5555_5555, 0,
           32'h0000_F00D, 32'h300, 32'hA7A7_A7A7, 4'b0010, 1'b1);

    // Misaligned word load and halfword store: flagged, no request, no stall.
    @(posedge clk); #1;
    ResultSrcM_i = 2'b01; LoadTypeM_i = 3'b010; ALUResultM_i = 32'h101;
    @(negedge clk);
    check("mis_lw/flag", MisalignM_o, 32'd1);
    check("mis_lw/stall", StallM_o, 32'd0);
    check("mis_lw/req", mem_req_o, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    MemWriteM_i = 3'b010; ALUResultM_i = 32'h201; WriteDataM_i = 32'h1111_2222;
    @(negedge clk);
    check("mis_sh/flag", MisalignM_o, 32'd1);
    check("mis_sh/stall", StallM_o, 32'd0);
    check("mis_sh/req", mem_req_o, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mis/req_later", mem_req_o, 32'd0);
    check("mis/flag_clear", MisalignM_o, 32'd0);

    // Stray ready pulse in IDLE is ignored.
    @(posedge clk); #1;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("stray_idle/req", mem_req_o, 32'd0);
    check("stray_idle/rdata", ReadDataM_o, 32'h0000_F00D);

    // Reset in the middle of BUSY, then a late ready.
    @(posedge clk); #1;
    ResultSrcM_i = 2'b01; LoadTypeM_i = 3'b010; ALUResultM_i = 32'h400;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy/req_before", mem_req_o, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy/req", mem_req_o, 32'd0);
    check("rst_busy/rdata", ReadDataM_o, 32'h0);
    check("rst_busy/stall_comb", StallM_o, 32'd1);
    idle_inputs();
    #1;
    check("rst_busy/stall_idle", StallM_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_ready/req", mem_req_o, 32'd0);
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("late_ready/req2", mem_req_o, 32'd0);
    check("late_ready/rdata", ReadDataM_o, 32'h0);
    check("late_ready/stall", StallM_o, 32'd0);

    access("lw_resume", 3'b000, 3'b010, 32'h500, 32'h0, 32'h1122_3344, 0,
           32'h1122_3344, 32'h500, 32'h0, 4'b0000, 1'b0);

    check("scoreboard/empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 The block SHALL have these ports: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have these ports: ResultSrcM_i, input, 2 bits, M-stage result select; 2'b01 means load.
REQ-004 The block SHALL have these ports: MemWriteM_i, input, 3 bits, store type: 000 none, 001 SB, 010 SH, 011 SW; other codes are treated as none.
REQ-005 The block SHALL have these ports: LoadTypeM_i, input, 3 bits, load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 The block SHALL have these ports: ALUResultM_i, input, 32 bits, byte address.
REQ-007 The block SHALL have these ports: WriteDataM_i, input, 32 bits, store data, right-aligned.
REQ-008 The block SHALL have these ports: mem_ready_i, input, 1 bit, memory-side completion.
REQ-009 The block SHALL have these ports: mem_rdata_i, input, 32 bits, memory read word, valid with mem_ready_i.
REQ-010 The block SHALL have these ports: mem_req_o, output, 1 bit, memory request.
REQ-011 The block SHALL have these ports: mem_we_o, output, 1 bit, write request.
REQ-012 The block SHALL have these ports: mem_addr_o, output, 32 bits, word-aligned address {ALUResultM_i[31:2],2'b00}.
REQ-013 The block SHALL have these ports: mem_wdata_o, output, 32 bits, lane-replicated store data.
REQ-014 The block SHALL have these ports: mem_wstrb_o, output, 4 bits, byte strobes.
REQ-015 The block SHALL have these ports: ReadDataM_o, output, 32 bits, extended load result.
REQ-016 The block SHALL have these ports: StallM_o, output, 1 bit, drives the active-low EN of the E/M pipeline register and the upstream stall logic.
REQ-017 The block SHALL have these ports: MisalignM_o, output, 1 bit, misaligned-access flag.

Function
REQ-018 Access SHALL be defined as (ResultSrcM_i==2'b01) or a valid store code; store SHALL take priority when both hold.
REQ-019 Misaligned SHALL be defined as: word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
REQ-020 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-021 IDLE SHALL transition to BUSY when an aligned access is present; otherwise it SHALL remain in IDLE.
REQ-022 BUSY SHALL transition to DONE on mem_ready_i=1; otherwise it SHALL remain in BUSY.
REQ-023 DONE SHALL transition to IDLE unconditionally.
REQ-024 StallM_o SHALL be combinational: 1 when an aligned access is present and state!=DONE, else 0.
REQ-025 A memory instruction SHALL occupy M for a minimum of 3 cycles; a non-memory instruction SHALL occupy M for 1 cycle.
REQ-026 mem_req_o SHALL be 1 exactly in BUSY.
REQ-027 mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o SHALL be valid throughout BUSY and stable while mem_req_o=1.
REQ-028 Store strobes SHALL be: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
REQ-029 Store data SHALL be: SB {4{WriteDataM_i[7:0]}}, SH {2{WriteDataM_i[15:0]}}, SW WriteDataM_i.
REQ-030 For loads, mem_wstrb_o SHALL be 0 and mem_we_o SHALL be 0.
REQ-031 On the BUSY->DONE edge, the selected lane of mem_rdata_i SHALL be registered into ReadDataM_o, sign- or zero-extended per LoadTypeM_i.
REQ-032 ReadDataM_o SHALL be held until the next load capture.
REQ-033 On the BUSY->DONE edge of a store, ReadDataM_o SHALL be left unchanged.
REQ-034 When a misaligned access is present in IDLE: no request SHALL be issued, StallM_o SHALL be 0, and MisalignM_o SHALL be combinational 1 for that cycle.
REQ-035 A mem_ready_i pulse outside BUSY SHALL be ignored.
REQ-036 In DONE, a new access SHALL NOT be started; back-to-back accesses SHALL pass through IDLE.

Reset
REQ-037 rst_n=0 SHALL at once force state=IDLE, mem_req_o=0 and ReadDataM_o=32'h0, asynchronously and including mid-BUSY.
REQ-038 StallM_o and MisalignM_o SHALL follow their combinational definitions during reset.
REQ-039 An in-flight request SHALL be abandoned at reset; a late mem_ready_i after reset SHALL be ignored.
REQ-040 Operation SHALL resume on the first rising edge after rst_n rises.

Verification
REQ-041 The bench SHALL cover: LW addr 0x100, mem_ready_i 1 cycle after request, rdata 0xDEADBEEF -> StallM_o=1 for 2 cycles, ReadDataM_o=0xDEADBEEF, FSM back in IDLE.
REQ-042 The bench SHALL cover: LB addr 0x103, rdata 0x80FF0000 -> ReadDataM_o=0xFFFFFF80; LBU same stimulus -> ReadDataM_o=0x00000080.
REQ-043 The bench SHALL cover: SH addr 0x202, data 0x1234ABCD -> mem_wstrb_o=4'b1100, mem_wdata_o=0xABCDABCD, mem_we_o=1, mem_addr_o=0x200.
REQ-044 The bench SHALL cover: LW addr 0x101 -> MisalignM_o=1, mem_req_o never 1, StallM_o=0.
REQ-045 The bench SHALL cover: SW with mem_ready_i held low for 5 cycles -> mem_req_o and all mem_* fields stable, StallM_o=1 throughout.
REQ-046 The bench SHALL cover: rst_n=0 mid-BUSY, then a stray mem_ready_i pulse -> mem_req_o=0 immediately, ReadDataM_o=0, FSM stays in IDLE.
